// File: rtl/duck_game_pkg.sv
// Shared duck-hunt game types and defaults.
// Used by the round controller, the duck sprite block and the HUD.
package duck_game_pkg;

    typedef enum logic [1:0] {
        TITLE  = 2'b00,
        READY  = 2'b01,
        FLY    = 2'b10,
        RESULT = 2'b11
    } game_state_t;

    localparam int SHELLS_DEF         = 3;
    localparam int DUCKS_DEF          = 10;
    localparam int PASS_HITS_DEF      = 6;
    localparam int SCORE_PER_DUCK_DEF = 500;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Brings the vsync-domain frame strobe onto Clk and emits a
// one-Clk tick per rising edge.
module frame_edge_detect (
    input  logic Clk,
    input  logic frame_clk,
    output logic tick
);

    logic sync0;
    logic sync1;

    always_ff @(posedge Clk) begin
        sync0 <= frame_clk;
        sync1 <= sync0;
    end

    assign tick = sync0 & ~sync1;

endmodule

// File: rtl/round_ctrl.sv
// Duck-hunt round controller: game FSM, shot request,
// shells, duck count, hits, score and round number.
module round_ctrl
    import duck_game_pkg::*;
#(
    parameter int SHELLS          = SHELLS_DEF,
    parameter int DUCKS_PER_ROUND = DUCKS_DEF,
    parameter int PASS_HITS       = PASS_HITS_DEF,
    parameter int READY_FRAMES    = 120,
    parameter int RESULT_FRAMES   = 90,
    parameter int SCORE_PER_DUCK  = SCORE_PER_DUCK_DEF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        trigger,
    input  logic        aim_hit,
    input  logic        bird_shot,
    input  logic        flew_away,
    output logic [1:0]  state,
    output logic        shot,
    output logic [1:0]  shells,
    output logic [3:0]  duck_num,
    output logic [3:0]  hits,
    output logic [15:0] score,
    output logic [7:0]  round_num,
    output logic        game_over
);

    localparam int MAX_FRAMES =
        (READY_FRAMES > RESULT_FRAMES) ? READY_FRAMES : RESULT_FRAMES;
    localparam int CNT_W = $clog2(MAX_FRAMES + 1);
    localparam logic [CNT_W-1:0] RDY_LAST = CNT_W'(READY_FRAMES - 1);
    localparam logic [CNT_W-1:0] RES_LAST = CNT_W'(RESULT_FRAMES - 1);

    logic tick;

    frame_edge_detect u_edge (
        .Clk       (Clk),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    game_state_t      state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             shot_q, shot_n;
    logic [1:0]       shells_q, shells_n;
    logic [3:0]       duck_q, duck_n;
    logic [3:0]       hits_q, hits_n;
    logic [15:0]      score_q, score_n;
    logic [7:0]       round_q, round_n;
    logic             over_q, over_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= TITLE;
            cnt_q    <= '0;
            shot_q   <= 1'b0;
            shells_q <= '0;
            duck_q   <= '0;
            hits_q   <= '0;
            score_q  <= '0;
            round_q  <= '0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            shot_q   <= shot_n;
            shells_q <= shells_n;
            duck_q   <= duck_n;
            hits_q   <= hits_n;
            score_q  <= score_n;
            round_q  <= round_n;
            over_q   <= over_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        shot_n   = 1'b0;
        shells_n = shells_q;
        duck_n   = duck_q;
        hits_n   = hits_q;
        score_n  = score_q;
        round_n  = round_q;
        over_n   = over_q;
        unique case (state_q)
            TITLE: begin
                if (start) begin
                    state_n  = READY;
                    cnt_n    = '0;
                    shells_n = 2'(SHELLS);
                    score_n  = '0;
                    round_n  = 8'd1;
                    duck_n   = '0;
                    hits_n   = '0;
                    over_n   = 1'b0;
                end
            end
            READY: begin
                if (tick) begin
                    if (cnt_q == RDY_LAST) begin
                        state_n = FLY;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            FLY: begin
                shot_n = shot_q;
                // flew_away outranks bird_shot; both outrank a trigger
                if (flew_away) begin
                    state_n = RESULT;
                    shot_n  = 1'b0;
                end else if (bird_shot) begin
                    state_n = RESULT;
                    shot_n  = 1'b0;
                    hits_n  = hits_q + 1'b1;
                    score_n = sat_add16(score_q, 16'(SCORE_PER_DUCK));
                end else if (trigger && shells_q != 2'd0) begin
                    shells_n = shells_q - 1'b1;
                    if (aim_hit) shot_n = 1'b1;
                end
            end
            RESULT: begin
                if (tick) begin
                    if (cnt_q == RES_LAST) begin
                        cnt_n = '0;
                        if (duck_q < 4'(DUCKS_PER_ROUND - 1)) begin
                            duck_n   = duck_q + 1'b1;
                            shells_n = 2'(SHELLS);
                            state_n  = READY;
                        end else if (hits_q >= 4'(PASS_HITS)) begin
                            round_n  = round_q + 8'd1;
                            duck_n   = '0;
                            hits_n   = '0;
                            shells_n = 2'(SHELLS);
                            state_n  = READY;
                        end else begin
                            over_n  = 1'b1;
                            state_n = TITLE;
                        end
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign state     = state_q;
    assign shot      = shot_q;
    assign shells    = shells_q;
    assign duck_num  = duck_q;
    assign hits      = hits_q;
    assign score     = score_q;
    assign round_num = round_q;
    assign game_over = over_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Randomized bench for round_ctrl against a behavioural game model.
module tb_round_ctrl;

    localparam int RF  = 2;
    localparam int SF  = 2;
    localparam int SH  = 3;
    localparam int ND  = 10;
    localparam int PH  = 6;
    localparam int PTS = 500;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic        start = 1'b0;
    logic        trigger = 1'b0;
    logic        aim_hit = 1'b0;
    logic        bird_shot = 1'b0;
    logic        flew_away = 1'b0;
    logic [1:0]  state;
    logic        shot;
    logic [1:0]  shells;
    logic [3:0]  duck_num;
    logic [3:0]  hits;
    logic [15:0] score;
    logic [7:0]  round_num;
    logic        game_over;

    round_ctrl #(
        .READY_FRAMES  (RF),
        .RESULT_FRAMES (SF)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .start     (start),
        .trigger   (trigger),
        .aim_hit   (aim_hit),
        .bird_shot (bird_shot),
        .flew_away (flew_away),
        .state     (state),
        .shot      (shot),
        .shells    (shells),
        .duck_num  (duck_num),
        .hits      (hits),
        .score     (score),
        .round_num (round_num),
        .game_over (game_over)
    );

    always #10 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // game model: 0 title, 1 ready, 2 fly, 3 result
    int m_st, m_frames, m_shot, m_shells, m_duck;
    int m_hits, m_score, m_round, m_over;
    int fc_prev1 = 0;
    int fc_prev2 = 0;
    bit want_hit = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                         tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_frames = 0; m_shot = 0; m_shells = 0; m_duck = 0;
        m_hits = 0; m_score = 0; m_round = 0; m_over = 0;
    endtask

    task automatic model_step();
        bit new_frame;
        new_frame = (fc_prev1 == 1) && (fc_prev2 == 0);
        fc_prev2 = fc_prev1;
        fc_prev1 = int'(frame_clk);
        if (Reset) begin
            model_reset();
            return;
        end
        if (m_st == 0) begin
            if (start) begin
                m_st = 1; m_frames = 0; m_shells = SH;
                m_score = 0; m_round = 1; m_duck = 0;
                m_hits = 0; m_over = 0;
            end
        end else if (m_st == 1) begin
            if (new_frame) begin
                m_frames++;
                if (m_frames == RF) begin
                    m_st = 2; m_frames = 0;
                end
            end
        end else if (m_st == 2) begin
            if (flew_away) begin
                m_st = 3; m_shot = 0;
            end else if (bird_shot) begin
                m_st = 3; m_shot = 0; m_hits++;
                m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
            end else if (trigger && m_shells > 0) begin
                m_shells--;
                if (aim_hit) m_shot = 1;
            end
        end else begin
            if (new_frame) begin
                m_frames++;
                if (m_frames == SF) begin
                    m_frames = 0;
                    if (m_duck < ND - 1) begin
                        m_duck++; m_shells = SH; m_st = 1;
                    end else if (m_hits >= PH) begin
                        m_round = (m_round + 1) % 256;
                        m_duck = 0; m_hits = 0; m_shells = SH; m_st = 1;
                    end else begin
                        m_over = 1; m_st = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("state", int'(state), m_st);
        check("shot", int'(shot), m_shot);
        check("shells", int'(shells), m_shells);
        check("duck_num", int'(duck_num), m_duck);
        check("hits", int'(hits), m_hits);
        check("score", int'(score), m_score);
        check("round_num", int'(round_num), m_round);
        check("game_over", int'(game_over), m_over);
    endtask

    // 0 chaos, 1 always hit, 2 mostly hit, 3 never hit, 4 idle
    task automatic drive(input int mode);
        start = 0; trigger = 0; aim_hit = 0;
        bird_shot = 0; flew_away = 0;
        frame_clk = ((cyc % 8) < 4) ? 1'b1 : 1'b0;
        if (mode == 0) begin
            start     = ($urandom % 8) == 0;
            trigger   = ($urandom % 3) == 0;
            aim_hit   = $urandom % 2;
            bird_shot = ($urandom % 10) == 0;
            flew_away = ($urandom % 12) == 0;
        end else if (mode != 4) begin
            if (m_st == 0) start = 1;
            if (m_st == 1)
                want_hit = (mode == 1) ? 1'b1 :
                           (mode == 3) ? 1'b0 : (($urandom % 4) != 0);
            if (m_st == 2) begin
                if (want_hit) begin
                    if (m_shot) begin
                        bird_shot = 1;
                        trigger = ($urandom % 2) == 0;
                    end else begin
                        trigger = 1; aim_hit = 1;
                    end
                end else if (m_shells > 0) begin
                    trigger = 1;
                end else begin
                    flew_away = 1;
                    trigger = ($urandom % 2) == 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        @(negedge Clk);
        cyc++;
        check_all();
    endtask

    initial begin
        int n;
        model_reset();
        repeat (4) begin
            drive(4);
            step();
        end
        Reset = 1'b0;

        n = 0;
        do begin
            drive(3); step(); n++;
        end while (!m_over && n < 3000);
        check("over_level", int'(game_over), 1);
        check("over_title", int'(state), 0);

        n = 0;
        do begin
            drive(1); step(); n++;
        end while (!(m_score == 65535 && m_st == 2 && m_shot == 1)
                   && n < 20000);
        check("score_sat", int'(score), 65535);
        check("shot_before_rst", int'(shot), 1);

        Reset = 1'b1;
        drive(4);
        step();
        check("rst_state", int'(state), 0);
        check("rst_shot", int'(shot), 0);
        check("rst_shells", int'(shells), 0);
        check("rst_duck", int'(duck_num), 0);
        check("rst_hits", int'(hits), 0);
        check("rst_score", int'(score), 0);
        check("rst_round", int'(round_num), 0);
        check("rst_over", int'(game_over), 0);
        Reset = 1'b0;

        repeat (4000) begin
            drive(2); step();
        end
        repeat (3000) begin
            drive(0); step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
